acc_control_unit: RTL

//  Instruction sequencer for the 8-bit accumulator datapath: A register, input/memory/add-sub mux, add/sub unit.

---
 rtl/acc_control_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/acc_control_unit.sv
// Instruction sequencer for the 8-bit accumulator processor: PC/IR, fetch/decode/execute FSM, A-path strobes.
// Optional macro ACC_CTRL_SINGLE_STEP_EN adds a `step` input that gates each FETCH on a step rising edge.
module acc_control_unit #(
  parameter int          ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W+2:0] mem_rdata,
  input  logic              enter,
  input  logic              Aeq0,
  input  logic              Apos,
`ifdef ACC_CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        Asel,
  output logic              Aload,
  output logic              Sub,
  output logic              halt,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W+2:0] r_ir;
  logic              r_enter_armed;

  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_operand;
  logic              w_in_done;
  logic              w_fetch_go;

  assign w_op      = r_ir[ADDR_W+2:ADDR_W];
  assign w_operand = r_ir[ADDR_W-1:0];

  // enter and step are plain synchronous levels; an IN consumes one enter press
  // (enter must return to 0 before another IN can complete).
  assign w_in_done = (r_state == ST_EXECUTE) && (w_op == OP_IN) && enter && r_enter_armed;

`ifdef ACC_CTRL_SINGLE_STEP_EN
  logic r_step_d;
  assign w_fetch_go = step & ~r_step_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_step_d <= 1'b0;
    else       r_step_d <= step;
  end
`else
  assign w_fetch_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_START;
      r_pc          <= ADDR_W'(RESET_PC);
      r_ir          <= '0;
      r_enter_armed <= 1'b1;
    end else begin
      if (!enter)         r_enter_armed <= 1'b1;
      else if (w_in_done) r_enter_armed <= 1'b0;

      case (r_state)
        ST_START: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (w_fetch_go) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 1'b1;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= ST_EXECUTE;
        ST_EXECUTE: begin
          case (w_op)
            OP_IN: begin
              if (w_in_done) r_state <= ST_FETCH;
            end
            OP_JZ: begin
              if (Aeq0) r_pc <= w_operand;
              r_state <= ST_FETCH;
            end
            OP_JPOS: begin
              if (Apos) r_pc <= w_operand;
              r_state <= ST_FETCH;
            end
            OP_HALT: r_state <= ST_HALTED;
            default: r_state <= ST_FETCH;
          endcase
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_START;
      endcase
    end
  end

  // Strobes decode from the registered state and IR so an async reset drops them immediately.
  always_comb begin
    mem_addr = r_pc;
    mem_we   = 1'b0;
    Asel     = 2'b00;
    Aload    = 1'b0;
    Sub      = 1'b0;
    case (r_state)
      ST_DECODE: mem_addr = w_operand;
      ST_EXECUTE: begin
        mem_addr = w_operand;
        case (w_op)
          OP_LOAD: begin
            Asel  = 2'b10;
            Aload = 1'b1;
          end
          OP_STORE: mem_we = 1'b1;
          OP_ADD:   Aload  = 1'b1;
          OP_SUB: begin
            Sub   = 1'b1;
            Aload = 1'b1;
          end
          OP_IN: begin
            Asel  = 2'b01;
            Aload = w_in_done;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign halt      = (r_state == ST_HALTED);
  assign pc_out    = r_pc;
  assign state_out = r_state;

endmodule
